dpc_mc: RTL

Parametrised multi-channel successor to the single-channel datapath controller in the filter design. It turns up/down request lines from CHANNELS independent sources into registered datapath commands, with optional hold-to-repeat and a clear gesture. Pending requests are arbitrated round-robin, and each command is issued to the datapath under an extready handshake. It sits between the user/control inputs and the filter datapath command port.

---
 rtl/myfilter_pkg.sv | 42 ++++
 rtl/dpc_mc_if.sv | 10 +
 rtl/dpc_chan.sv | 82 ++++++++
 rtl/dpc_mc.sv | 116 +++++++++++
 4 files changed

// File: rtl/myfilter_pkg.sv
// Shared types for the filter datapath command path.
package myfilter_pkg;

  localparam int unsigned DPC_CHW   = 4;
  localparam int unsigned DPC_MAXCH = 1 << DPC_CHW;

  typedef enum logic [1:0] {
    DPC_NOP   = 2'd0,
    DPC_UP    = 2'd1,
    DPC_DOWN  = 2'd2,
    DPC_CLEAR = 2'd3
  } dpc_op_t;

  typedef struct packed {
    dpc_op_t              op;
    logic [DPC_CHW-1:0]   ch;
  } dpc_cmd_t;

  // Pending-op update for one channel given this cycle's up/down events.
  // NOP doubles as "nothing pending".
  function automatic dpc_op_t dpc_next_pend(dpc_op_t cur, logic up_ev, logic dn_ev);
    dpc_op_t nxt;
    nxt = cur;
    if (up_ev && dn_ev) begin
      nxt = DPC_CLEAR;
    end else if (up_ev) begin
      case (cur)
        DPC_DOWN:  nxt = DPC_NOP;
        DPC_CLEAR: nxt = DPC_CLEAR;
        default:   nxt = DPC_UP;
      endcase
    end else if (dn_ev) begin
      case (cur)
        DPC_UP:    nxt = DPC_NOP;
        DPC_CLEAR: nxt = DPC_CLEAR;
        default:   nxt = DPC_DOWN;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/dpc_mc_if.sv
// Command port between the controller and the filter datapath.
interface dpc_mc_if;
  import myfilter_pkg::*;

  dpc_cmd_t cmd_out;
  logic     extready_in;

  modport master (output cmd_out, input extready_in);
  modport slave  (input cmd_out, output extready_in);
endinterface

// File: rtl/dpc_chan.sv
// One request channel: edge detect, hold-to-repeat timer and pending op.
module dpc_chan
  import myfilter_pkg::*;
#(
  parameter int unsigned REPEAT_EN     = 1,
  parameter int unsigned REPEAT_DELAY  = 16,
  parameter int unsigned REPEAT_PERIOD = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    ul,
  input  logic    dl,
  input  logic    clr,
  output dpc_op_t pend,
  output logic    pending
);

  localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DLY   = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] PER   = CW'(REPEAT_PERIOD);
  localparam logic [CW-1:0] SAT   = CW'(CNT_MAX);

  logic          ul_q, dl_q;
  logic          ul_edge, dl_edge;
  logic          held_one;
  logic [CW-1:0] cnt_q, cnt_d, target;
  logic          rep_q, rep_d;
  logic          tick_c;
  logic          up_ev, dn_ev;
  dpc_op_t       base, pend_d;

  assign ul_edge  = ul & ~ul_q;
  assign dl_edge  = dl & ~dl_q;
  assign held_one = ul ^ dl;
  assign target   = rep_q ? PER : DLY;

  // Repeat timer: counts cycles since the last edge or tick while exactly one line is held.
  always_comb begin
    cnt_d  = cnt_q;
    rep_d  = rep_q;
    tick_c = 1'b0;
    if (REPEAT_EN == 0 || !held_one || ul_edge || dl_edge) begin
      cnt_d = '0;
      rep_d = 1'b0;
    end else if (cnt_q + CW'(1) == target) begin
      tick_c = 1'b1;
      cnt_d  = '0;
      rep_d  = 1'b1;
    end else if (cnt_q != SAT) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Grant clear is applied first so same-cycle events stay pending.
  always_comb begin
    up_ev  = ul_edge | (tick_c & ul);
    dn_ev  = dl_edge | (tick_c & dl);
    base   = clr ? DPC_NOP : pend;
    pend_d = dpc_next_pend(base, up_ev, dn_ev);
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ul_q    <= 1'b0;
      dl_q    <= 1'b0;
      cnt_q   <= '0;
      rep_q   <= 1'b0;
      pend    <= DPC_NOP;
      pending <= 1'b0;
    end else begin
      ul_q    <= ul;
      dl_q    <= dl;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      pend    <= pend_d;
      pending <= (pend_d != DPC_NOP);
    end
  end

endmodule

// File: rtl/dpc_mc.sv
// Multi-channel datapath controller: per-channel request capture,
// round-robin arbitration and a held command under an extready handshake.
module dpc_mc
  import myfilter_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned REPEAT_EN     = 1,
  parameter int unsigned REPEAT_DELAY  = 16,
  parameter int unsigned REPEAT_PERIOD = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] ul_in,
  input  logic [CHANNELS-1:0] dl_in,
  dpc_mc_if.master            dp,
  output logic [CHANNELS-1:0] pending_out
);

  localparam int unsigned SW = DPC_CHW + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t               state_q, state_d;
  dpc_op_t              pend     [CHANNELS];
  dpc_op_t              pend_pad [DPC_MAXCH];
  logic [CHANNELS-1:0]  clr_c;
  logic [DPC_CHW-1:0]   last_grant;
  logic [DPC_CHW-1:0]   gnt_c;
  logic                 found_c;
  logic                 grant_c;

  // Per-channel request logic.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    dpc_chan #(
      .REPEAT_EN     (REPEAT_EN),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .ul      (ul_in[i]),
      .dl      (dl_in[i]),
      .clr     (clr_c[i]),
      .pend    (pend[i]),
      .pending (pending_out[i])
    );
  end

  // Pad the pending view to the full channel-id range so it indexes cleanly.
  for (genvar i = 0; i < DPC_MAXCH; i++) begin : g_pad
    if (i < CHANNELS) begin : g_real
      assign pend_pad[i] = pend[i];
    end else begin : g_none
      assign pend_pad[i] = DPC_NOP;
    end
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    logic [SW-1:0] cand;
    found_c = 1'b0;
    gnt_c   = '0;
    cand    = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      cand = SW'(last_grant) + SW'(1) + SW'(k);
      if (cand >= SW'(CHANNELS)) cand = cand - SW'(CHANNELS);
      if (!found_c && pend_pad[cand[DPC_CHW-1:0]] != DPC_NOP) begin
        found_c = 1'b1;
        gnt_c   = cand[DPC_CHW-1:0];
      end
    end
  end

  assign grant_c = (state_q == ST_IDLE) && found_c;

  // Clear the granted channel's pending op on the grant edge.
  always_comb begin
    clr_c = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      clr_c[i] = grant_c && (gnt_c == DPC_CHW'(i));
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (found_c) state_d = ST_ISSUE;
      ST_ISSUE: if (dp.extready_in) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Command and last-grant registers; command held until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp.cmd_out <= '{op: DPC_NOP, ch: '0};
      last_grant <= DPC_CHW'(CHANNELS - 1);
    end else if (grant_c) begin
      dp.cmd_out <= '{op: pend_pad[gnt_c], ch: gnt_c};
      last_grant <= gnt_c;
    end else if (state_q == ST_ISSUE && dp.extready_in) begin
      dp.cmd_out <= '{op: DPC_NOP, ch: '0};
    end
  end

endmodule
